// File: rtl/audio_voice_ctrl.sv
// ============================================================================
// audio_voice_ctrl
//
// Multi-voice audio command controller. Decode strobes a command
// (cmd_valid + instruction bits); the addressed or auto-allocated channel
// loads volume, sound select and a note duration. Each channel then runs
// its own IDLE/PLAY(/FADE) state machine, timed by a shared tick prescaler.
//
// Optional feature macro: AUDIO_FADE_EN
//   defined   : an expired note enters FADE and its volume ramps down one
//               step per tick before the channel returns to IDLE.
//   undefined : an expired note goes straight to IDLE (default build).
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   cmd_valid  one-cycle command strobe from decode
//   cmd_inst   command word: vol[4:0] sel[8:5] dur[16:9] ch[19:17] auto[20]
//   ch_vol     per-channel volume, channel i at [i*VOL_W +: VOL_W]
//   ch_sel     per-channel sound select, channel i at [i*SEL_W +: SEL_W]
//   ch_active  channel i is not IDLE
//   ch_start   one-cycle retrigger pulse per channel
//   cmd_ch     channel used by the most recent accepted command
//   all_busy   no channel is IDLE
//
// The channel field is decoded as the full 3-bit slot [19:17] (enough for
// 8 voices). Any value >= NUM_CH, including ones whose upper bits fall
// outside CH_W, is treated as out of range and the command is dropped
// rather than aliased onto a lower channel.
// ============================================================================
module audio_voice_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int VOL_W    = 5,
  parameter int SEL_W    = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [25:0]                   cmd_inst,
  output logic [NUM_CH*VOL_W-1:0]       ch_vol,
  output logic [NUM_CH*SEL_W-1:0]       ch_sel,
  output logic [NUM_CH-1:0]             ch_active,
  output logic [NUM_CH-1:0]             ch_start,
  output logic [$clog2(NUM_CH)-1:0]     cmd_ch,
  output logic                          all_busy
);

  localparam int CH_W     = $clog2(NUM_CH);
  localparam int PS_W     = $clog2(TICK_DIV);
  localparam int VOL_LSB  = 0;
  localparam int SEL_LSB  = 5;
  localparam int DUR_LSB  = 9;
  localparam int CH_LSB   = 17;
  localparam int AUTO_BIT = 20;
  localparam logic [3:0]      NUM_CH_L = 4'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_FADE = 2'd2
  } state_t;

  function automatic logic [VOL_W-1:0] sat_dec_vol(input logic [VOL_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [DUR_W-1:0] sat_dec_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  logic [PS_W-1:0]  presc;
  logic             tick;
  state_t           state_q [NUM_CH];
  logic [VOL_W-1:0] vol_q   [NUM_CH];
  logic [SEL_W-1:0] sel_q   [NUM_CH];
  logic [DUR_W-1:0] cnt_q   [NUM_CH];
  logic [CH_W-1:0]  steal_ptr;

  // The tick takes effect on the edge where the prescaler wraps to 0.
  assign tick = (presc == PS_W'(TICK_DIV - 1));

  // ---- p0: command decode and target selection (combinational) ----
  logic             vld_p0;
  logic [VOL_W-1:0] cmd_vol_p0;
  logic [SEL_W-1:0] cmd_sel_p0;
  logic [DUR_W-1:0] cmd_dur_p0;
  logic [2:0]       cmd_chf_p0;
  logic             cmd_auto_p0;
  logic             unused_inst;

  assign vld_p0      = cmd_valid;
  assign cmd_vol_p0  = cmd_inst[VOL_LSB +: VOL_W];
  assign cmd_sel_p0  = cmd_inst[SEL_LSB +: SEL_W];
  assign cmd_dur_p0  = cmd_inst[DUR_LSB +: DUR_W];
  assign cmd_chf_p0  = cmd_inst[CH_LSB +: 3];
  assign cmd_auto_p0 = cmd_inst[AUTO_BIT];
  assign unused_inst = ^cmd_inst[25:21];

  logic              idle_hit;
  logic [CH_W-1:0]   idle_idx;
`ifdef AUDIO_FADE_EN
  logic              fade_hit;
  logic [CH_W-1:0]   fade_idx;
`endif
  logic              tgt_ok_p0;
  logic [CH_W-1:0]   tgt_idx_p0;
  logic              steal_use_p0;
  logic [CH_W-1:0]   steal_next;
  logic [NUM_CH-1:0] hit_p0;

  always_comb begin
    idle_hit = 1'b0;
    idle_idx = '0;
`ifdef AUDIO_FADE_EN
    fade_hit = 1'b0;
    fade_idx = '0;
`endif
    // Scan high to low so the lowest matching index is the one kept.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_IDLE) begin
        idle_hit = 1'b1;
        idle_idx = CH_W'(i);
      end
`ifdef AUDIO_FADE_EN
      if (state_q[i] == ST_FADE) begin
        fade_hit = 1'b1;
        fade_idx = CH_W'(i);
      end
`endif
    end

    steal_next   = (steal_ptr == LAST_CH) ? '0 : steal_ptr + 1'b1;
    tgt_ok_p0    = 1'b0;
    tgt_idx_p0   = '0;
    steal_use_p0 = 1'b0;
    if (cmd_auto_p0) begin
      tgt_ok_p0 = 1'b1;
      if (idle_hit) begin
        tgt_idx_p0 = idle_idx;
`ifdef AUDIO_FADE_EN
      end else if (fade_hit) begin
        tgt_idx_p0 = fade_idx;
`endif
      end else begin
        tgt_idx_p0   = steal_ptr;
        steal_use_p0 = 1'b1;
      end
    end else begin
      tgt_ok_p0  = ({1'b0, cmd_chf_p0} < NUM_CH_L);
      tgt_idx_p0 = cmd_chf_p0[CH_W-1:0];
    end

    for (int i = 0; i < NUM_CH; i++) begin
      hit_p0[i] = vld_p0 && tgt_ok_p0 && (tgt_idx_p0 == CH_W'(i));
    end
  end

  // ---- p1: registered channel state, visible one cycle after the command ----
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      steal_ptr <= '0;
      cmd_ch    <= '0;
      ch_start  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        vol_q[i]   <= '0;
        sel_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      presc <= tick ? '0 : presc + 1'b1;

      if (vld_p0 && tgt_ok_p0) begin
        cmd_ch <= tgt_idx_p0;
        if (steal_use_p0) steal_ptr <= steal_next;
      end

      for (int i = 0; i < NUM_CH; i++) begin
        ch_start[i] <= hit_p0[i] && (cmd_vol_p0 != '0);
        if (hit_p0[i]) begin
          // A command always overrides a same-cycle expiry or fade step.
          if (cmd_vol_p0 == '0) begin
            state_q[i] <= ST_IDLE;
            vol_q[i]   <= '0;
            sel_q[i]   <= '0;
            cnt_q[i]   <= '0;
          end else begin
            state_q[i] <= ST_PLAY;
            vol_q[i]   <= cmd_vol_p0;
            sel_q[i]   <= cmd_sel_p0;
            cnt_q[i]   <= cmd_dur_p0;
          end
        end else if (tick) begin
          case (state_q[i])
            ST_PLAY: begin
              // cnt == 0 means sustain: no timer activity.
              if (cnt_q[i] != '0) begin
                cnt_q[i] <= sat_dec_dur(cnt_q[i]);
                if (cnt_q[i] == DUR_W'(1)) begin
`ifdef AUDIO_FADE_EN
                  state_q[i] <= ST_FADE;
`else
                  state_q[i] <= ST_IDLE;
                  vol_q[i]   <= '0;
                  sel_q[i]   <= '0;
`endif
                end
              end
            end
`ifdef AUDIO_FADE_EN
            ST_FADE: begin
              vol_q[i] <= sat_dec_vol(vol_q[i]);
              if (sat_dec_vol(vol_q[i]) == '0) begin
                state_q[i] <= ST_IDLE;
                sel_q[i]   <= '0;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ch_vol[g*VOL_W +: VOL_W] = vol_q[g];
    assign ch_sel[g*SEL_W +: SEL_W] = sel_q[g];
    assign ch_active[g]             = (state_q[g] != ST_IDLE);
  end

  assign all_busy = &ch_active;

endmodule
